// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: double-buffered scan controller for four 74LV595 seven-segment chains
//
// Ports:
//   clk_i           system clock, shared with driver_74lv595
//   resetn_i        asynchronous active-low reset
//   frame_done_i    one-cycle pulse per driver frame (driver RCLK)
//   enable_i        0 blanks all output words at the next frame boundary
//   wr_valid_i      back-buffer write request; wr_ready_o accepts it
//   wr_chain_i      target chain 0..3
//   wr_digit_i      target digit; values >= DIGITS are accepted and dropped
//   wr_seg_i        segment pattern, bit 7 = dp
//   commit_valid_i  request to copy back buffer to front buffer at the next scan wrap
//   commit_ready_o  one-cycle pulse in the cycle the copy happens
//   data_0_o..3_o   {onehot(scan_digit), segments} per chain, registered
//   scan_digit_o    digit currently presented
module seg_scan_ctrl #(
    parameter int DIGITS = 8,
    parameter int DWELL  = 4
) (
    input  logic        clk_i,
    input  logic        resetn_i,
    input  logic        frame_done_i,
    input  logic        enable_i,
    input  logic        wr_valid_i,
    output logic        wr_ready_o,
    input  logic [1:0]  wr_chain_i,
    input  logic [2:0]  wr_digit_i,
    input  logic [7:0]  wr_seg_i,
    input  logic        commit_valid_i,
    output logic        commit_ready_o,
    output logic [15:0] data_0_o,
    output logic [15:0] data_1_o,
    output logic [15:0] data_2_o,
    output logic [15:0] data_3_o,
    output logic [2:0]  scan_digit_o
);
    localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;

    logic [3:0][7:0][7:0] back_q, back_d, front_q, front_d;
    logic [3:0][15:0]     data_q, data_d;
    logic [DW-1:0]        dwell_q, dwell_d;
    logic [2:0]           digit_q, digit_d;
    logic                 pending_q, pending_d;
    logic                 wr_fire, adv, wrap, commit;
    logic [7:0]           sel;

    always_comb begin
        wr_fire   = wr_valid_i & ~pending_q;
        adv       = frame_done_i & (dwell_q == DW'(DWELL - 1));
        wrap      = adv & (digit_q == 3'(DIGITS - 1));
        // the copy only happens at a wrap, so digit 0 is the first digit shown from the new image
        commit    = wrap & pending_q;
        dwell_d   = frame_done_i ? (adv ? '0 : dwell_q + 1'b1) : dwell_q;
        digit_d   = wrap ? 3'd0 : adv ? digit_q + 3'd1 : digit_q;
        pending_d = ~commit & (pending_q | commit_valid_i);
        back_d    = back_q;
        if (wr_fire && int'(wr_digit_i) < DIGITS)
            back_d[wr_chain_i][wr_digit_i] = wr_seg_i;
        front_d   = commit ? back_q : front_q;
        sel       = 8'd1 << digit_d;
        data_d    = data_q;
        // words change only on frame boundaries so the driver never latches a torn word
        for (int k = 0; k < 4; k++)
            if (frame_done_i)
                data_d[k] = enable_i ? {sel, front_d[k][digit_d]} : 16'h0000;
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            back_q    <= '0;
            front_q   <= '0;
            data_q    <= '0;
            dwell_q   <= '0;
            digit_q   <= '0;
            pending_q <= 1'b0;
        end else begin
            back_q    <= back_d;
            front_q   <= front_d;
            data_q    <= data_d;
            dwell_q   <= dwell_d;
            digit_q   <= digit_d;
            pending_q <= pending_d;
        end
    end

    assign wr_ready_o     = ~pending_q;
    assign commit_ready_o = commit;
    assign data_0_o       = data_q[0];
    assign data_1_o       = data_q[1];
    assign data_2_o       = data_q[2];
    assign data_3_o       = data_q[3];
    assign scan_digit_o   = digit_q;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: directed and random checks of seg_scan_ctrl against a frame-count reference model
module tb_seg_scan_ctrl;
    localparam int DIGITS = 6;
    localparam int DWELL  = 4;
    localparam int PER    = DIGITS * DWELL;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        fd = 1'b0, en = 1'b0, wv = 1'b0, cv = 1'b0;
    logic [1:0]  wc = '0;
    logic [2:0]  wd = '0;
    logic [7:0]  ws = '0;
    logic        wr_ready, commit_ready;
    logic [15:0] d0, d1, d2, d3;
    logic [2:0]  sd;

    int total = 0;
    int bad = 0;

    logic [7:0]  back[4][8];
    logic [7:0]  front[4][8];
    logic [15:0] md[4];
    int          fcnt;
    bit          pend;
    bit          acc_q, cexp_q;

    always #5 clk = ~clk;

    seg_scan_ctrl #(.DIGITS(DIGITS), .DWELL(DWELL)) dut (
        .clk_i(clk), .resetn_i(resetn), .frame_done_i(fd), .enable_i(en),
        .wr_valid_i(wv), .wr_ready_o(wr_ready), .wr_chain_i(wc), .wr_digit_i(wd),
        .wr_seg_i(ws), .commit_valid_i(cv), .commit_ready_o(commit_ready),
        .data_0_o(d0), .data_1_o(d1), .data_2_o(d2), .data_3_o(d3),
        .scan_digit_o(sd)
    );

    task automatic chk(input string tag, input logic [15:0] o, input logic [15:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic mreset();
        for (int c = 0; c < 4; c++) begin
            md[c] = 16'h0;
            for (int g = 0; g < 8; g++) begin
                back[c][g] = 8'h0;
                front[c][g] = 8'h0;
            end
        end
        fcnt = 0;
        pend = 0;
    endtask

    // one clock cycle: check outputs against the model, then advance the model with the current inputs
    task automatic step();
        int nf, dig;
        #2;
        nf = (fcnt + 1) % PER;
        cexp_q = fd && pend && nf == 0;
        acc_q = wv && !pend;
        chk("wr_ready", {15'b0, wr_ready}, {15'b0, !pend});
        chk("commit_ready", {15'b0, commit_ready}, {15'b0, cexp_q});
        chk("scan_digit", {13'b0, sd}, 16'(fcnt / DWELL));
        chk("data_0", d0, md[0]);
        chk("data_1", d1, md[1]);
        chk("data_2", d2, md[2]);
        chk("data_3", d3, md[3]);
        if (cexp_q) front = back;
        if (acc_q && int'(wd) < DIGITS) back[wc][wd] = ws;
        pend = cexp_q ? 1'b0 : (pend | cv);
        if (fd) begin
            fcnt = nf;
            dig = fcnt / DWELL;
            for (int k = 0; k < 4; k++)
                md[k] = en ? {8'(1 << dig), front[k][dig]} : 16'h0;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit seen;
        mreset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_data_0", d0, 16'h0);
        chk("rst_wr_ready", {15'b0, wr_ready}, 16'h1);
        resetn = 1'b1;
        en = 1'b1;

        // first frame after reset shows digit 0 blank segments
        fd = 1'b1;
        step();
        fd = 1'b0;
        chk("first_frame", d0, 16'h0100);

        // write, commit, scan
        wv = 1'b1; wc = 2'd0; wd = 3'd0; ws = 8'h3F;
        step();
        wc = 2'd2; wd = 3'd5; ws = 8'h06; cv = 1'b1;
        step();
        wv = 1'b0;
        fd = 1'b1;
        seen = 0;
        for (int i = 0; i < 2 * PER && !seen; i++) begin
            step();
            seen = cexp_q;
        end
        cv = 1'b0;
        chk("commit_seen", {15'b0, seen}, 16'h1);
        chk("commit_d0", d0, 16'h013F);
        chk("commit_d2", d2, 16'h0100);
        repeat (5 * DWELL) step();
        chk("digit5_d2", d2, 16'h2006);
        chk("digit5_d0", d0, 16'h2000);
        fd = 1'b0;

        // commit gating: write with commit, second write stalls until after commit_ready
        wv = 1'b1; wc = 2'd1; wd = 3'd3; ws = 8'hFF; cv = 1'b1;
        step();
        chk("gate_first_acc", {15'b0, acc_q}, 16'h1);
        ws = 8'h55;
        fd = 1'b1;
        seen = 0;
        for (int i = 0; i < 2 * PER && !seen; i++) begin
            step();
            seen = cexp_q;
            chk("gate_stall", {15'b0, acc_q}, 16'h0);
        end
        cv = 1'b0;
        chk("gate_commit_seen", {15'b0, seen}, 16'h1);
        fd = 1'b0;
        step();
        chk("gate_second_acc", {15'b0, acc_q}, 16'h1);
        wv = 1'b0;
        fd = 1'b1;
        repeat (3 * DWELL) step();
        chk("gate_front_ff", d1, 16'h08FF);
        fd = 1'b0;

        // dwell: one frame every 32 cycles for a full scan
        for (int f = 0; f < PER + 2; f++) begin
            fd = 1'b1;
            step();
            fd = 1'b0;
            repeat (31) step();
        end

        // blanking takes effect at the next frame only
        en = 1'b0;
        repeat (3) step();
        fd = 1'b1;
        step();
        fd = 1'b0;
        chk("blank_d0", d0, 16'h0);
        en = 1'b1;
        fd = 1'b1;
        step();
        fd = 1'b0;
        chk("unblank_sel", {8'h0, d0[15:8]}, {8'h0, 8'(1 << (fcnt / DWELL))});

        // invalid digits are accepted and dropped
        wv = 1'b1; wc = 2'd0; wd = 3'd6; ws = 8'hAA;
        step();
        chk("inv6_acc", {15'b0, acc_q}, 16'h1);
        wd = 3'd7;
        step();
        chk("inv7_acc", {15'b0, acc_q}, 16'h1);
        wv = 1'b0;

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            fd = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 15) == 0) en = ~en;
            if (!wv && $urandom_range(0, 2) == 0) begin
                wv = 1'b1;
                wc = 2'($urandom);
                wd = 3'($urandom);
                ws = 8'($urandom);
            end
            if (!cv && $urandom_range(0, 19) == 0) cv = 1'b1;
            step();
            if (acc_q) wv = 1'b0;
            if (cexp_q) cv = 1'b0;
        end

        // reset mid-scan with a commit pending
        en = 1'b1; wv = 1'b0; cv = 1'b1; fd = 1'b1;
        step();
        step();
        resetn = 1'b0;
        #1;
        chk("rstmid_d0", d0, 16'h0);
        chk("rstmid_d1", d1, 16'h0);
        chk("rstmid_d2", d2, 16'h0);
        chk("rstmid_d3", d3, 16'h0);
        chk("rstmid_digit", {13'b0, sd}, 16'h0);
        chk("rstmid_wr_ready", {15'b0, wr_ready}, 16'h1);
        chk("rstmid_commit_ready", {15'b0, commit_ready}, 16'h0);
        mreset();
        cv = 1'b0; fd = 1'b0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        fd = 1'b1;
        step();
        fd = 1'b0;
        chk("rstmid_first_frame", d0, 16'h0100);
        repeat (2 * PER) begin
            fd = 1'b1;
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
